mode_router: RTL
================

// Module: mode_router
// PURPOSE
//  Parametrised replacement for the clock top's mode-select path: debounces NUM_SW push switches and NUM_MODES dip bits.
//  Decodes a one-hot dip pattern to an active mode and routes press pulses to that mode only.
//  Muxes that mode's character byte toward lcd_driver, with a timed space-blank window on every mode change.
//  Sits between debounce/pin inputs and the mode_* blocks / lcd_driver.
// PARAMETERS
//  NUM_MODES    4       number of display modes (>=2); dip_sw width
//  NUM_SW       4       number of push switches
//  CHAR_W       8       character byte width
//  DEBOUNCE_CYC 250000  consecutive stable cycles before an input change is accepted
//  BLANK_CYC    32      cycles data_char is forced to space after a mode change (>=1)
// PORTS
//  clk            in   1                  system clock
//  rst            in   1                  asynchronous reset, active-high
//  dip_sw         in   NUM_MODES          mode select, raw pins
//  sw_in          in   NUM_SW             push switches, raw pins, active-high
//  mode_data      in   NUM_MODES*CHAR_W   char from mode m at [m*CHAR_W +: CHAR_W]
//  mode_sw_pulse  out  NUM_MODES*NUM_SW   1-cycle press pulse to mode m at [m*NUM_SW +: NUM_SW]
//  data_char      out  CHAR_W             char to lcd_driver
//  active_mode    out  MODE_W             current mode index, MODE_W = max(1,$clog2(NUM_MODES))
//  mode_changed   out  1                  1-cycle pulse on entry to BLANK
//  blank          out  1                  high while in BLANK
// BEHAVIOUR
//  Reset (async): all outputs 0; active_mode=0; state RUN; debounced levels 0; counters 0; sync flops 0.
//  Input sync: every dip_sw/sw_in bit passes a 2-flop synchroniser before debounce.
//  Debounce, per bit, own counter:
//   - synced != stable: counter++; counter reaches DEBOUNCE_CYC-1 -> stable<=synced, counter<=0.
//   - synced == stable: counter<=0 (any bounce restarts the count).
//  Press edge: stable sw bit 0->1 gives press[i] high exactly 1 cycle; 1->0 gives nothing.
//  Mode decode from debounced dip:
//   - exactly one bit k set -> target=k.
//   - zero bits or >1 bit set -> target=0.
//   - combinational popcount check; no priority encoding.
//  FSM (RUN, BLANK):
//   - RUN, target!=active_mode: next cycle state=BLANK, active_mode<=target, mode_changed=1 for that cycle, blank counter<=0.
//   - BLANK: counter++ each cycle; counter==BLANK_CYC-1 -> RUN. blank=1 throughout BLANK (exactly BLANK_CYC cycles).
//   - BLANK, target!=active_mode: active_mode<=target, counter<=0, mode_changed pulses again; remains BLANK.
//  Routing, registered, 1-cycle latency:
//   - RUN: mode_sw_pulse[active*NUM_SW+i] <= press[i]; all other lanes 0.
//   - BLANK: all lanes 0. Presses arriving in BLANK are dropped, not queued.
//   - Press in the same cycle RUN->BLANK is decided: dropped.
//  data_char, registered, 1-cycle latency:
//   - RUN: mode_data slice of active_mode.
//   - BLANK: 8'h20 (low CHAR_W bits of 0x20).
//  Every mode_sw_pulse bit is never high for more than 1 consecutive cycle.
//  At most one lane group is non-zero in any cycle.
//  Reset mid-BLANK: returns to RUN, mode 0, no mode_changed pulse.
// TESTING (bench: DEBOUNCE_CYC=4, BLANK_CYC=8, NUM_MODES=4, NUM_SW=4)
//  1. Reset; dip=0001; sw_in[2] high 20 cycles -> one pulse on mode_sw_pulse[2], ~7 cycles after the rise (sync + debounce + register); active_mode=0, no mode_changed.
//  2. sw_in[1] toggled every 2 cycles for 20 cycles, then held 0 -> no pulse on any lane.
//  3. dip 0001->0100 held -> mode_changed 1 cycle; blank=1 for exactly 8 cycles; data_char=0x20 meanwhile.
//     Then active_mode=2 and data_char=mode_data[23:16] one cycle later.
//  4. dip=0110, then 0000 -> target 0 both times; active_mode returns/stays 0; never 1 or 2.
//  5. Press matured during BLANK -> all mode_sw_pulse lanes 0. Same press after BLANK ends -> pulse on active mode's lane only.
//  6. rst asserted at BLANK cycle 3 -> all outputs 0 immediately (async). After release: state RUN, active_mode=0, blank=0.

Source files
------------

// File: rtl/mode_router.sv
// mode_router
//   Mode-select path for the clock top. Synchronises and debounces the dip
//   (mode select) and push-switch pins, decodes a one-hot dip pattern into an
//   active mode, routes single-cycle press pulses to that mode's lane group
//   and muxes that mode's character byte toward lcd_driver. Every mode change
//   opens a BLANK window during which data_char is a space and presses are
//   dropped.
//
// Ports
//   clk            in   1                  system clock
//   rst            in   1                  asynchronous reset, active-high
//   dip_sw         in   NUM_MODES          mode select, raw pins
//   sw_in          in   NUM_SW             push switches, raw pins, active-high
//   mode_data      in   NUM_MODES*CHAR_W   char from mode m at [m*CHAR_W +: CHAR_W]
//   mode_sw_pulse  out  NUM_MODES*NUM_SW   press pulse to mode m at [m*NUM_SW +: NUM_SW]
//   data_char      out  CHAR_W             char to lcd_driver
//   active_mode    out  MODE_W             current mode index
//   mode_changed   out  1                  1-cycle pulse on entry to BLANK
//   blank          out  1                  high while in BLANK
module mode_router #(
    parameter int NUM_MODES    = 4,
    parameter int NUM_SW       = 4,
    parameter int CHAR_W       = 8,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int BLANK_CYC    = 32,
    localparam int MODE_W      = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MODES-1:0]          dip_sw,
    input  logic [NUM_SW-1:0]             sw_in,
    input  logic [NUM_MODES*CHAR_W-1:0]   mode_data,
    output logic [NUM_MODES*NUM_SW-1:0]   mode_sw_pulse,
    output logic [CHAR_W-1:0]             data_char,
    output logic [MODE_W-1:0]             active_mode,
    output logic                          mode_changed,
    output logic                          blank
);

    localparam int NB   = NUM_MODES + NUM_SW;
    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int BL_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [CHAR_W-1:0] SPACE_CHAR = CHAR_W'(32'h20);

    typedef enum logic {
        ST_RUN,
        ST_BLANK
    } state_t;

    // dip bits occupy the low end, switches the high end of the shared path
    logic [NB-1:0]     raw_in;
    logic [NB-1:0]     sync1;
    logic [NB-1:0]     sync2;
    logic [NB-1:0]     stable;
    logic [NB-1:0]     stable_prev;
    logic [DB_W-1:0]   db_cnt [NB];

    logic [NUM_MODES-1:0] dip_stable;
    logic [NUM_SW-1:0]    press;
    logic [MODE_W-1:0]    one_idx;
    logic [MODE_W-1:0]    target;

    state_t               state, state_next;
    logic [MODE_W-1:0]    active_next;
    logic [BL_W-1:0]      blank_cnt, cnt_next;
    logic                 changed_next;
    logic                 route_off;
    logic [NUM_MODES*NUM_SW-1:0] pulse_next;
    logic [CHAR_W-1:0]    char_sel;
    logic [CHAR_W-1:0]    char_next;

    assign raw_in = {sw_in, dip_sw};

    // 2-flop synchroniser followed by a per-bit debounce counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            stable_prev <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1       <= raw_in;
            sync2       <= sync1;
            stable_prev <= stable;
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign dip_stable = stable[NUM_MODES-1:0];
    assign press      = stable[NB-1:NUM_MODES] & ~stable_prev[NB-1:NUM_MODES];

    // OR of set-bit indices is the index itself when exactly one bit is set
    always_comb begin
        one_idx = '0;
        for (int unsigned i = 0; i < NUM_MODES; i++) begin
            if (dip_stable[i]) begin
                one_idx = one_idx | MODE_W'(i);
            end
        end
        target = ($countones(dip_stable) == 1) ? one_idx : '0;
    end

    always_comb begin
        state_next   = state;
        active_next  = active_mode;
        cnt_next     = blank_cnt;
        changed_next = 1'b0;
        if (target != active_mode) begin
            state_next   = ST_BLANK;
            active_next  = target;
            cnt_next     = '0;
            changed_next = 1'b1;
        end else if (state == ST_BLANK) begin
            if (blank_cnt == BL_W'(BLANK_CYC - 1)) begin
                state_next = ST_RUN;
            end else begin
                cnt_next = blank_cnt + 1'b1;
            end
        end
    end

    // The RUN cycle that decides a mode change is treated as already blank:
    // its press is dropped and a space is registered, so data_char is a space
    // for every cycle blank is high.
    assign route_off = (state == ST_BLANK) || (target != active_mode);

    always_comb begin
        pulse_next = '0;
        char_sel   = '0;
        for (int unsigned m = 0; m < NUM_MODES; m++) begin
            if (MODE_W'(m) == active_mode) begin
                pulse_next[m*NUM_SW +: NUM_SW] = press;
                char_sel = mode_data[m*CHAR_W +: CHAR_W];
            end
        end
        if (route_off) begin
            pulse_next = '0;
        end
        char_next = route_off ? SPACE_CHAR : char_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_RUN;
            active_mode   <= '0;
            blank_cnt     <= '0;
            mode_changed  <= 1'b0;
            mode_sw_pulse <= '0;
            data_char     <= '0;
        end else begin
            state         <= state_next;
            active_mode   <= active_next;
            blank_cnt     <= cnt_next;
            mode_changed  <= changed_next;
            mode_sw_pulse <= pulse_next;
            data_char     <= char_next;
        end
    end

    assign blank = (state == ST_BLANK);

endmodule
